// File: rtl/axi4_stream_pkg.sv
// ---------------------------------------------------------------------------
// axi4_stream_pkg
// Shared types for the AXI4-Stream demux scheduler.
//   axi4_stream_sched_st_t : scheduler FSM state (IDLE / RUN / DRAIN)
//   SCHED_ST_W             : encoded width of the state, for debug taps
// ---------------------------------------------------------------------------
package axi4_stream_pkg;

  localparam int SCHED_ST_W = 2;

  typedef enum logic [SCHED_ST_W-1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } axi4_stream_sched_st_t;

endpackage : axi4_stream_pkg

// File: rtl/axi4_stream_demux_sched_rr_next_sel.sv
// ---------------------------------------------------------------------------
// rr_next_sel
// Purely combinational: finds the next set bit of ena_i strictly above
// cur_i, wrapping around modulo SN. If cur_i is the only set bit it is
// returned unchanged. Feeding cur_i = SN-1 yields the lowest set bit.
//   ena_i   [SN-1:0] candidate mask
//   cur_i   [SW-1:0] current index
//   nxt_o   [SW-1:0] next index (cur_i when nothing is set)
//   found_o          1 when ena_i has at least one bit set
// ---------------------------------------------------------------------------
module rr_next_sel #(
  parameter int SN = 2,
  parameter int SW = $clog2(SN)
) (
  input  logic [SN-1:0] ena_i,
  input  logic [SW-1:0] cur_i,
  output logic [SW-1:0] nxt_o,
  output logic          found_o
);

  logic [SW-1:0] above;
  logic [SW-1:0] lowest;
  logic          above_found;
  logic          low_found;

  // Scan downwards so the final hit in each category is the smallest index.
  always_comb begin
    above       = '0;
    lowest      = '0;
    above_found = 1'b0;
    low_found   = 1'b0;
    for (int i = SN - 1; i >= 0; i--) begin
      if (ena_i[i]) begin
        lowest    = SW'(i);
        low_found = 1'b1;
        if (i > int'(cur_i)) begin
          above       = SW'(i);
          above_found = 1'b1;
        end
      end
    end
  end

  assign found_o = low_found;
  assign nxt_o   = above_found ? above : (low_found ? lowest : cur_i);

endmodule : rr_next_sel

// File: rtl/axi4_stream_demux_sched.sv
// ---------------------------------------------------------------------------
// axi4_stream_demux_sched
// Schedules which output port of an AXI4-Stream demux receives traffic.
// Switches ports only on packet boundaries, either to a fixed port or
// round-robin over an enable mask, after a programmable packet quota.
//
// Handshake: a transfer is str_tvalid & str_tready observed on a rising
// clk edge; str_tlast on a transfer marks end-of-packet (EOP). The taps
// are observe-only; flow is controlled solely through the registered
// gate output, which the integration ANDs into source TVALID/TREADY.
//
// Ports
//   clk, rstn                 clock, asynchronous active-low reset
//   ctl_start / ctl_stop      single-cycle control pulses
//   cfg_mode                  0 fixed cfg_sel, 1 round-robin over cfg_ena
//   cfg_sel [SW], cfg_ena [SN], cfg_pkt [CW]  scheduling configuration
//   str_tvalid/tready/tlast   stream taps
//   sel [SW], gate            registered demux select and pass gate
//   sts_run, sts_err, sts_cnt running flag, sticky error, packet count
//   dbg_state                 current FSM state
// ---------------------------------------------------------------------------
module axi4_stream_demux_sched
  import axi4_stream_pkg::*;
#(
  parameter int SN = 2,
  parameter int SW = $clog2(SN),
  parameter int CW = 16
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  ctl_start,
  input  logic                  ctl_stop,
  input  logic                  cfg_mode,
  input  logic [SW-1:0]         cfg_sel,
  input  logic [SN-1:0]         cfg_ena,
  input  logic [CW-1:0]         cfg_pkt,
  input  logic                  str_tvalid,
  input  logic                  str_tready,
  input  logic                  str_tlast,
  output logic [SW-1:0]         sel,
  output logic                  gate,
  output logic                  sts_run,
  output logic                  sts_err,
  output logic [CW-1:0]         sts_cnt,
  output axi4_stream_sched_st_t dbg_state
);

  axi4_stream_sched_st_t state_q, state_d;
  logic [SW-1:0] sel_q, sel_d;
  logic          gate_q, gate_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          err_q, err_d;
  logic          inpkt_q, inpkt_d;
  logic [CW-1:0] lim_q, lim_d;

  logic          xfer;
  logic          eop;
  logic          mid_pkt;
  logic [CW-1:0] cnt_inc;
  logic [CW-1:0] cfg_lim;
  logic [SW-1:0] rr_cur;
  logic [SW-1:0] rr_nxt;
  logic          rr_found;

  assign xfer    = str_tvalid & str_tready;
  assign eop     = xfer & str_tlast;
  // A packet is open if a beat was already taken or a non-last beat is
  // being taken right now.
  assign mid_pkt = inpkt_q | (xfer & ~str_tlast);
  assign cnt_inc = cnt_q + CW'(1);
  assign cfg_lim = (cfg_pkt == '0) ? CW'(1) : cfg_pkt;

  // From IDLE, searching above SN-1 wraps to the lowest enabled port.
  assign rr_cur = (state_q == ST_IDLE) ? SW'(SN - 1) : sel_q;

  rr_next_sel #(
    .SN (SN),
    .SW (SW)
  ) u_rr_next_sel (
    .ena_i   (cfg_ena),
    .cur_i   (rr_cur),
    .nxt_o   (rr_nxt),
    .found_o (rr_found)
  );

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= ST_IDLE;
      sel_q   <= '0;
      gate_q  <= 1'b0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
      inpkt_q <= 1'b0;
      lim_q   <= CW'(1);
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      gate_q  <= gate_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      inpkt_q <= inpkt_d;
      lim_q   <= lim_d;
    end
  end

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    gate_d  = gate_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    inpkt_d = inpkt_q;
    lim_d   = lim_q;

    // Only beats that pass the gate belong to a scheduled packet.
    if (gate_q && xfer) begin
      inpkt_d = ~str_tlast;
    end

    unique case (state_q)
      ST_IDLE: begin
        // Stop has priority over a coincident start.
        if (ctl_start && !ctl_stop) begin
          if (cfg_mode && !rr_found) begin
            err_d = 1'b1;
          end else begin
            state_d = ST_RUN;
            gate_d  = 1'b1;
            cnt_d   = '0;
            err_d   = 1'b0;
            lim_d   = cfg_lim;
            sel_d   = cfg_mode ? rr_nxt : cfg_sel;
          end
        end
      end

      ST_RUN: begin
        if (eop) begin
          if (cnt_inc == lim_q) begin
            // Quota reached: this is an advance point, configuration is
            // resampled here.
            cnt_d = '0;
            lim_d = cfg_lim;
            if (!cfg_mode) begin
              sel_d = cfg_sel;
            end else if (!rr_found) begin
              err_d   = 1'b1;
              state_d = ST_IDLE;
              gate_d  = 1'b0;
            end else begin
              sel_d = rr_nxt;
            end
          end else begin
            cnt_d = cnt_inc;
          end
          if (ctl_stop) begin
            state_d = ST_IDLE;
            gate_d  = 1'b0;
          end
        end else if (ctl_stop) begin
          if (mid_pkt) begin
            state_d = ST_DRAIN;
          end else begin
            state_d = ST_IDLE;
            gate_d  = 1'b0;
          end
        end
      end

      ST_DRAIN: begin
        if (eop) begin
          state_d = ST_IDLE;
          gate_d  = 1'b0;
        end
      end

      default: begin
        state_d = ST_IDLE;
        gate_d  = 1'b0;
      end
    endcase
  end

  assign sel       = sel_q;
  assign gate      = gate_q;
  assign sts_run   = (state_q != ST_IDLE);
  assign sts_err   = err_q;
  assign sts_cnt   = cnt_q;
  assign dbg_state = state_q;

endmodule : axi4_stream_demux_sched

// File: tb/tb_axi4_stream_demux_sched.sv
// ---------------------------------------------------------------------------
// tb_axi4_stream_demux_sched
// Self-checking bench for axi4_stream_demux_sched with SN = 4.
// Inputs change 1 ns after the rising edge; outputs are sampled on the
// falling edge (or 1 ns after the rising edge for post-edge state).
// ---------------------------------------------------------------------------
module tb_axi4_stream_demux_sched;
  import axi4_stream_pkg::*;

  localparam int SN = 4;
  localparam int SW = 2;
  localparam int CW = 16;

  logic                  clk;
  logic                  rstn;
  logic                  ctl_start;
  logic                  ctl_stop;
  logic                  cfg_mode;
  logic [SW-1:0]         cfg_sel;
  logic [SN-1:0]         cfg_ena;
  logic [CW-1:0]         cfg_pkt;
  logic                  str_tvalid;
  logic                  str_tready;
  logic                  str_tlast;
  logic [SW-1:0]         sel;
  logic                  gate;
  logic                  sts_run;
  logic                  sts_err;
  logic [CW-1:0]         sts_cnt;
  axi4_stream_sched_st_t dbg_state;

  axi4_stream_demux_sched #(
    .SN (SN),
    .SW (SW),
    .CW (CW)
  ) dut (
    .clk        (clk),
    .rstn       (rstn),
    .ctl_start  (ctl_start),
    .ctl_stop   (ctl_stop),
    .cfg_mode   (cfg_mode),
    .cfg_sel    (cfg_sel),
    .cfg_ena    (cfg_ena),
    .cfg_pkt    (cfg_pkt),
    .str_tvalid (str_tvalid),
    .str_tready (str_tready),
    .str_tlast  (str_tlast),
    .sel        (sel),
    .gate       (gate),
    .sts_run    (sts_run),
    .sts_err    (sts_err),
    .sts_cnt    (sts_cnt),
    .dbg_state  (dbg_state)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_fail   = 0;
  logic [SW-1:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_bus();
    str_tvalid = 1'b0;
    str_tready = 1'b0;
    str_tlast  = 1'b0;
  endtask

  task automatic pulse_start();
    ctl_start = 1'b1;
    tick();
    ctl_start = 1'b0;
  endtask

  task automatic pulse_stop();
    ctl_stop = 1'b1;
    tick();
    ctl_stop = 1'b0;
  endtask

  // One beat: the expected select for it must already be queued.
  task automatic beat(input logic last);
    logic [SW-1:0] e;
    str_tvalid = 1'b1;
    str_tready = 1'b1;
    str_tlast  = last;
    @(negedge clk);
    if (exp_q.size() == 0) begin
      check("sb_underflow", 32'd1, 32'd0);
    end else begin
      e = exp_q.pop_front();
      check("beat_sel", 32'(sel), 32'(e));
    end
    check("beat_gate", 32'(gate), 32'd1);
    tick();
  endtask

  task automatic send_pkt(input int nbeats, input logic [SW-1:0] es);
    for (int b = 0; b < nbeats; b++) begin
      exp_q.push_back(es);
      beat(b == nbeats - 1);
    end
  endtask

  task automatic set_cfg(input logic m, input logic [SW-1:0] s,
                         input logic [SN-1:0] en, input logic [CW-1:0] p);
    cfg_mode = m;
    cfg_sel  = s;
    cfg_ena  = en;
    cfg_pkt  = p;
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic               mode;
    logic [SW-1:0]      csel;
    logic [SN-1:0]      ena;
    logic [CW-1:0]      pkt;
    int                 npkt;
    int                 nbeat;
    logic [5:0][SW-1:0] esel;  // select per packet, [0] = first packet
    logic [5:0][CW-1:0] ecnt;  // sts_cnt after each packet's EOP
  } vec_t;

  vec_t vecs[6];

  initial begin
    // fixed port 1, quota 3, five 4-beat packets
    vecs[0] = '{mode: 1'b0, csel: 2'd1, ena: 4'b0000, pkt: 16'd3, npkt: 5, nbeat: 4,
                esel: {2'd0, 2'd1, 2'd1, 2'd1, 2'd1, 2'd1},
                ecnt: {16'd0, 16'd2, 16'd1, 16'd0, 16'd2, 16'd1}};
    // round-robin over 1011, quota 1, six 2-beat packets
    vecs[1] = '{mode: 1'b1, csel: 2'd0, ena: 4'b1011, pkt: 16'd1, npkt: 6, nbeat: 2,
                esel: {2'd3, 2'd1, 2'd0, 2'd3, 2'd1, 2'd0},
                ecnt: {16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0}};
    // round-robin over 0110, quota 2, single-beat packets, wrap 2 -> 1
    vecs[2] = '{mode: 1'b1, csel: 2'd3, ena: 4'b0110, pkt: 16'd2, npkt: 6, nbeat: 1,
                esel: {2'd1, 2'd1, 2'd2, 2'd2, 2'd1, 2'd1},
                ecnt: {16'd0, 16'd1, 16'd0, 16'd1, 16'd0, 16'd1}};
    // fixed port 3, quota 0 behaves as 1
    vecs[3] = '{mode: 1'b0, csel: 2'd3, ena: 4'b1111, pkt: 16'd0, npkt: 3, nbeat: 3,
                esel: {2'd0, 2'd0, 2'd0, 2'd3, 2'd3, 2'd3},
                ecnt: {16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0}};
    // round-robin with a single enabled port stays put
    vecs[4] = '{mode: 1'b1, csel: 2'd0, ena: 4'b1000, pkt: 16'd1, npkt: 3, nbeat: 2,
                esel: {2'd0, 2'd0, 2'd0, 2'd3, 2'd3, 2'd3},
                ecnt: {16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0}};
    // fixed port 2, quota 2, single-beat packets
    vecs[5] = '{mode: 1'b0, csel: 2'd2, ena: 4'b0000, pkt: 16'd2, npkt: 4, nbeat: 1,
                esel: {2'd0, 2'd0, 2'd2, 2'd2, 2'd2, 2'd2},
                ecnt: {16'd0, 16'd0, 16'd0, 16'd1, 16'd0, 16'd1}};
  end

  // ---------------- main sequence ----------------
  initial begin
    rstn      = 1'b0;
    ctl_start = 1'b0;
    ctl_stop  = 1'b0;
    set_cfg(1'b0, '0, '0, '0);
    idle_bus();

    // reset state
    @(negedge clk);
    check("rst_sel",  32'(sel),     32'd0);
    check("rst_gate", 32'(gate),    32'd0);
    check("rst_run",  32'(sts_run), 32'd0);
    check("rst_err",  32'(sts_err), 32'd0);
    check("rst_cnt",  32'(sts_cnt), 32'd0);
    @(posedge clk);
    #1 rstn = 1'b1;
    tick();

    // table-driven scheduling runs
    for (int v = 0; v < 6; v++) begin
      set_cfg(vecs[v].mode, vecs[v].csel, vecs[v].ena, vecs[v].pkt);
      pulse_start();
      check("start_run",  32'(sts_run), 32'd1);
      check("start_gate", 32'(gate),    32'd1);
      check("start_cnt",  32'(sts_cnt), 32'd0);
      for (int p = 0; p < vecs[v].npkt; p++) begin
        send_pkt(vecs[v].nbeat, vecs[v].esel[p]);
        check("pkt_cnt", 32'(sts_cnt), 32'(vecs[v].ecnt[p]));
      end
      idle_bus();
      pulse_stop();
      check("stop_run",  32'(sts_run), 32'd0);
      check("stop_gate", 32'(gate),    32'd0);
    end

    // start and stop together: stop wins
    set_cfg(1'b0, 2'd1, '0, 16'd1);
    ctl_start = 1'b1;
    ctl_stop  = 1'b1;
    tick();
    ctl_start = 1'b0;
    ctl_stop  = 1'b0;
    check("startstop_run", 32'(sts_run), 32'd0);

    // stop on the 2nd beat of a 4-beat packet drains to EOP
    set_cfg(1'b0, 2'd0, '0, 16'd5);
    pulse_start();
    exp_q.push_back(2'd0);
    beat(1'b0);
    ctl_stop = 1'b1;
    exp_q.push_back(2'd0);
    beat(1'b0);
    ctl_stop = 1'b0;
    check("drain_state", 32'(dbg_state), 32'(ST_DRAIN));
    check("drain_run",   32'(sts_run),   32'd1);
    check("drain_gate",  32'(gate),      32'd1);
    exp_q.push_back(2'd0);
    beat(1'b0);
    exp_q.push_back(2'd0);
    beat(1'b1);
    idle_bus();
    check("drain_end_gate",  32'(gate),      32'd0);
    check("drain_end_run",   32'(sts_run),   32'd0);
    check("drain_end_state", 32'(dbg_state), 32'(ST_IDLE));

    // round-robin start with empty mask, then a valid one
    set_cfg(1'b1, 2'd0, 4'b0000, 16'd1);
    pulse_start();
    check("err_run", 32'(sts_run), 32'd0);
    check("err_set", 32'(sts_err), 32'd1);
    tick();
    check("err_sticky", 32'(sts_err), 32'd1);
    cfg_ena = 4'b0100;
    pulse_start();
    check("err_clr_sel", 32'(sel),     32'd2);
    check("err_clr",     32'(sts_err), 32'd0);
    check("err_clr_run", 32'(sts_run), 32'd1);
    pulse_stop();
    check("err_stop_run", 32'(sts_run), 32'd0);

    // cfg_sel change mid-packet only takes effect after EOP
    set_cfg(1'b0, 2'd0, '0, 16'd1);
    pulse_start();
    exp_q.push_back(2'd0);
    beat(1'b0);
    cfg_sel = 2'd2;
    for (int b = 0; b < 3; b++) begin
      exp_q.push_back(2'd0);
      beat(b == 2);
    end
    idle_bus();
    check("midcfg_sel", 32'(sel), 32'd2);
    exp_q.push_back(2'd2);
    beat(1'b1);
    idle_bus();
    pulse_stop();

    // stop coincident with EOP goes straight to IDLE
    set_cfg(1'b0, 2'd1, '0, 16'd4);
    pulse_start();
    exp_q.push_back(2'd1);
    beat(1'b0);
    ctl_stop = 1'b1;
    exp_q.push_back(2'd1);
    beat(1'b1);
    ctl_stop = 1'b0;
    idle_bus();
    check("stop_eop_run",  32'(sts_run), 32'd0);
    check("stop_eop_gate", 32'(gate),    32'd0);

    // round-robin advance with mask cleared mid-packet
    set_cfg(1'b1, 2'd0, 4'b0001, 16'd1);
    pulse_start();
    exp_q.push_back(2'd0);
    beat(1'b0);
    cfg_ena = 4'b0000;
    exp_q.push_back(2'd0);
    beat(1'b1);
    idle_bus();
    check("adv_err",  32'(sts_err), 32'd1);
    check("adv_run",  32'(sts_run), 32'd0);
    check("adv_gate", 32'(gate),    32'd0);

    // start while running is ignored
    set_cfg(1'b0, 2'd1, '0, 16'd2);
    pulse_start();
    check("restart_err_clr", 32'(sts_err), 32'd0);
    cfg_sel = 2'd3;
    pulse_start();
    check("restart_sel", 32'(sel), 32'd1);
    send_pkt(2, 2'd1);
    check("restart_cnt", 32'(sts_cnt), 32'd1);
    idle_bus();
    pulse_stop();

    // asynchronous reset mid-packet on port 3
    set_cfg(1'b0, 2'd3, '0, 16'd3);
    pulse_start();
    send_pkt(1, 2'd3);
    exp_q.push_back(2'd3);
    beat(1'b0);
    check("pre_rst_cnt", 32'(sts_cnt), 32'd1);
    #2 rstn = 1'b0;
    #1;
    check("arst_sel",  32'(sel),     32'd0);
    check("arst_gate", 32'(gate),    32'd0);
    check("arst_cnt",  32'(sts_cnt), 32'd0);
    check("arst_run",  32'(sts_run), 32'd0);
    idle_bus();
    @(posedge clk);
    #1 rstn = 1'b1;
    tick();
    tick();
    check("post_rst_run",  32'(sts_run), 32'd0);
    check("post_rst_gate", 32'(gate),    32'd0);

    check("sb_empty", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_axi4_stream_demux_sched
